lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised pseudo-random sequence generator, successor to the fixed 16-bit Fibonacci LFSR.
- Width, tap set and seed are generic; Fibonacci or Galois mode is selectable at run time.
- Output uses a valid/ready stream, so the sequence advances only when a consumer takes a word.
- Adds run-time seed load, all-zero lock-up protection and hardware period measurement; feeds test-pattern and scrambler blocks.

Parameters:
- WIDTH, 16, state/output width in bits (>=3).
- FIB_TAPS, 16'hB400, Fibonacci tap mask; bit i set means state[i] enters the XOR feedback.
- GAL_POLY, 16'h6801, Galois reduction mask; XORed into the shifted state when the old MSB is 1.
- SAFE_SEED, 16'h0001, nonzero substitute for any all-zero seed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  WIDTH  seed captured during reset.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled on every accepted step.
- load  in  1  one-cycle request to reseed from seed.
- seed  in  WIDTH  run-time seed value.
- out  out  WIDTH  current LFSR state.
- out_valid  out  1  out holds a valid word.
- out_ready  in  1  consumer accepts out this cycle.
- period_done  out  1  one-cycle pulse when the state returns to the reference seed.
- period_len  out  WIDTH  length of the last completed period.
- lockup  out  1  sticky flag: an all-zero seed was substituted.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state <= init, or SAFE_SEED if init==0.
  - ref <= the same value; lockup <= (init==0).
  - out_valid <= 0, step_cnt <= 0, period_len <= 0, period_done <= 0.
  - Reset mid-operation discards everything; there is no partial state.
- First cycle after reset deasserts: out_valid <= 1. It then stays 1 until the next reset.
- Accepted step is out_valid && out_ready; the new state appears on out the following cycle (latency 1).
- Fibonacci step: state <= {state[WIDTH-2:0], ^(state & FIB_TAPS)}.
- Galois step: state <= {state[WIDTH-2:0],1'b0} ^ (state[WIDTH-1] ? GAL_POLY : 0).
- Step counting:
  - Each accepted step increments step_cnt (WIDTH bits, wraps modulo 2^WIDTH).
  - If the next state equals ref: period_done <= 1 for one cycle, period_len <= step_cnt+1, step_cnt <= 0.
  - period_done is 0 on every other cycle.
- Load (load=1, reset=0):
  - state and ref <= seed, or SAFE_SEED if seed==0; in the zero case lockup <= 1.
  - step_cnt <= 0; period_done <= 0.
  - Load takes priority over a simultaneous accepted step; that step is dropped and the consumer sees the new seed next cycle.
- lockup is cleared only by a reset with nonzero init.
- Mode change between steps is legal:
  - The period reference is kept.
  - period_len is only meaningful if mode stayed constant for the whole period.
- out_ready with out_valid=0 has no effect.
- The state never becomes all-zero when the masks are nonzero and correspond to a primitive polynomial.

Decomposition:
- Package lfsr_pkg holds:
  - typedef enum logic {LFSR_FIB, LFSR_GAL} lfsr_mode_e;
  - default mask constants for 8/16/32-bit maximal polynomials.
- One combinational sub-module, lfsr_next, computes the next state from state, mode and both masks. It is reused by the scrambler.
- Counter, handshake and load logic stay in lfsr_gen.

Test Plan:
- Fibonacci sequence: reset with init=16'hACE1, mode=0, out_ready=1 -> out=ACE1, then 59C3, then B387; out_valid=1 from the cycle after reset.
- Galois step: init=16'hACE1, mode=1, one accepted step -> out=16'h31C3.
- Back-pressure and load: out_ready=0 for 10 cycles -> out is held. Then assert load with seed=16'h1234 together with out_ready=1 -> next out=1234, step dropped, step_cnt=0.
- Lock-up: reset with init=0 -> out=0001, lockup=1. A later load with seed=0 -> out=0001, lockup stays 1. Reset with init=5 -> lockup=0.
- Period measurement: Fibonacci, default taps, continuous ready -> period_done pulses exactly once after 65535 accepted steps, with period_len=16'hFFFF and out=init.
- Reset mid-stream: assert reset after 100 steps with init=16'hBEEF -> next cycle out=BEEF, out_valid=0, period_len=0; out_valid=1 the cycle after.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and default feedback masks for the LFSR family.
package lfsr_pkg;

  typedef enum logic {LFSR_FIB, LFSR_GAL} lfsr_mode_e;

  // Maximal-length masks. Fibonacci masks select the state bits XORed into
  // bit 0; Galois masks are the polynomial without its implicit top term.
  localparam logic [7:0]  FIB_TAPS_8  = 8'hB8;
  localparam logic [7:0]  GAL_POLY_8  = 8'h1D;
  localparam logic [15:0] FIB_TAPS_16 = 16'hB400;
  localparam logic [15:0] GAL_POLY_16 = 16'h6801;
  localparam logic [31:0] FIB_TAPS_32 = 32'h8020_0003;
  localparam logic [31:0] GAL_POLY_32 = 32'h0040_0007;

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function for one LFSR step, Fibonacci or Galois.
// Shared with the scrambler, so masks arrive as ports rather than parameters.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] state,
  input  lfsr_mode_e       mode,
  input  logic [WIDTH-1:0] fib_taps,
  input  logic [WIDTH-1:0] gal_poly,
  output logic [WIDTH-1:0] nxt
);

  logic [WIDTH-1:0] shifted;

  assign shifted = {state[WIDTH-2:0], 1'b0};

  // Fibonacci feeds the tap parity into bit 0; Galois folds the polynomial
  // into the shifted word whenever the bit shifted out was set.
  always_comb begin
    nxt = shifted;
    if (mode == LFSR_FIB) begin
      nxt[0] = ^(state & fib_taps);
    end else if (state[WIDTH-1]) begin
      nxt = shifted ^ gal_poly;
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Stream-output LFSR with run-time mode, reseed, zero-seed protection and
// period measurement against the most recent seed.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] FIB_TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0] GAL_POLY  = 16'h6801,
  parameter logic [WIDTH-1:0] SAFE_SEED = 16'h0001
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] init,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             lockup
);

  logic [WIDTH-1:0] state, ref_state, step_cnt, nxt;
  logic [WIDTH-1:0] init_safe, seed_safe;
  logic             step;

  // An all-zero seed would freeze the register, so swap in a known nonzero one.
  assign init_safe = (init == '0) ? SAFE_SEED : init;
  assign seed_safe = (seed == '0) ? SAFE_SEED : seed;
  assign step      = out_valid && out_ready;
  assign out       = state;

  lfsr_next #(.WIDTH(WIDTH)) u_next (
    .state    (state),
    .mode     (lfsr_mode_e'(mode)),
    .fib_taps (FIB_TAPS),
    .gal_poly (GAL_POLY),
    .nxt      (nxt)
  );

  // State, handshake, reseed and period counter. Load wins over a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= init_safe;
      ref_state   <= init_safe;
      lockup      <= (init == '0);
      out_valid   <= 1'b0;
      step_cnt    <= '0;
      period_len  <= '0;
      period_done <= 1'b0;
    end else begin
      out_valid   <= 1'b1;
      period_done <= 1'b0;
      if (load) begin
        state     <= seed_safe;
        ref_state <= seed_safe;
        step_cnt  <= '0;
        if (seed == '0) lockup <= 1'b1;
      end else if (step) begin
        state <= nxt;
        if (nxt == ref_state) begin
          period_done <= 1'b1;
          period_len  <= step_cnt + 1'b1;
          step_cnt    <= '0;
        end else begin
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: directed test-plan cases, a full-period run
// and a randomized phase, all checked against an arithmetic reference model.
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        reset, mode, load, out_ready;
  logic [15:0] init, seed;
  logic [15:0] out, period_len;
  logic        out_valid, period_done, lockup;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] out;
    logic        valid;
    logic        done;
    logic [15:0] len;
    logic        lock;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [15:0] m_state, m_ref, m_cnt, m_len;
  logic        m_valid, m_done, m_lock;

  lfsr_gen dut (
    .clk(clk), .reset(reset), .init(init), .mode(mode), .load(load),
    .seed(seed), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .period_done(period_done), .period_len(period_len), .lockup(lockup)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_step(logic [15:0] s, logic gal);
    int v, r;
    v = int'(s);
    if (!gal) r = ((v << 1) & 'hFFFF) | ($countones(v & 'hB400) % 2);
    else      r = ((v << 1) & 'hFFFF) ^ ((v >= 'h8000) ? 'h6801 : 0);
    return r[15:0];
  endfunction

  function automatic logic [15:0] fix0(logic [15:0] s);
    return (s == 16'h0) ? 16'h0001 : s;
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clk();
    logic [15:0] n;
    if (reset) begin
      m_state = fix0(init); m_ref = fix0(init); m_lock = (init == 16'h0);
      m_valid = 1'b0; m_cnt = 16'h0; m_len = 16'h0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (load) begin
        m_state = fix0(seed); m_ref = fix0(seed); m_cnt = 16'h0;
        if (seed == 16'h0) m_lock = 1'b1;
      end else if (m_valid && out_ready) begin
        n = ref_step(m_state, mode);
        if (n == m_ref) begin
          m_done = 1'b1; m_len = m_cnt + 16'h1; m_cnt = 16'h0;
        end else begin
          m_cnt = m_cnt + 16'h1;
        end
        m_state = n;
      end
      m_valid = 1'b1;
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_clk();
    e.out = m_state; e.valid = m_valid; e.done = m_done;
    e.len = m_len;   e.lock = m_lock;
    sb.push_back(e);
    #1;
  endtask

  task automatic spot(string name, logic [15:0] act, logic [15:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // monitor: one expected response per clock, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (out !== e.out || out_valid !== e.valid || period_done !== e.done ||
            period_len !== e.len || lockup !== e.lock) begin
          miscompares++;
          $display("FAIL scoreboard @%0t: got out=%h v=%b done=%b len=%h lock=%b, expected out=%h v=%b done=%b len=%h lock=%b",
                   $time, out, out_valid, period_done, period_len, lockup,
                   e.out, e.valid, e.done, e.len, e.lock);
        end
      end
    end
  end

  initial begin
    int pulses;
    reset = 1'b1; init = 16'hACE1; mode = 1'b0; load = 1'b0;
    seed = 16'h0; out_ready = 1'b1;

    // Fibonacci sequence from ACE1
    cycle();
    @(negedge clk); spot("reset_valid", {15'h0, out_valid}, 16'h0);
    reset = 1'b0; cycle();
    @(negedge clk); spot("fib0", out, 16'hACE1); spot("valid_up", {15'h0, out_valid}, 16'h1);
    cycle(); @(negedge clk); spot("fib1", out, 16'h59C3);
    cycle(); @(negedge clk); spot("fib2", out, 16'hB387);

    // Galois single step
    reset = 1'b1; mode = 1'b1; cycle(); reset = 1'b0; cycle(); cycle();
    @(negedge clk); spot("gal1", out, 16'h31C3);

    // back-pressure then load colliding with a step
    out_ready = 1'b0;
    repeat (10) begin cycle(); @(negedge clk); spot("hold", out, 16'h31C3); end
    load = 1'b1; seed = 16'h1234; out_ready = 1'b1; cycle(); load = 1'b0;
    @(negedge clk); spot("load", out, 16'h1234);
    cycle();

    // lock-up protection
    reset = 1'b1; init = 16'h0; cycle(); reset = 1'b0;
    @(negedge clk); spot("zero_init", out, 16'h0001); spot("lock_set", {15'h0, lockup}, 16'h1);
    cycle(); load = 1'b1; seed = 16'h0; cycle(); load = 1'b0;
    @(negedge clk); spot("zero_seed", out, 16'h0001); spot("lock_keep", {15'h0, lockup}, 16'h1);
    reset = 1'b1; init = 16'h0005; cycle(); reset = 1'b0;
    @(negedge clk); spot("lock_clr", {15'h0, lockup}, 16'h0);

    // reset mid-stream
    mode = 1'b0; repeat (101) cycle();
    reset = 1'b1; init = 16'hBEEF; cycle(); reset = 1'b0;
    @(negedge clk);
    spot("mid_out", out, 16'hBEEF); spot("mid_valid", {15'h0, out_valid}, 16'h0);
    spot("mid_len", period_len, 16'h0);
    cycle(); @(negedge clk); spot("mid_valid_up", {15'h0, out_valid}, 16'h1);

    // full period, Fibonacci, continuous ready
    reset = 1'b1; init = 16'hACE1; cycle(); reset = 1'b0; cycle();
    pulses = 0;
    repeat (65535) begin
      cycle(); @(negedge clk);
      if (period_done) pulses++;
    end
    spot("period_pulses", 16'(pulses), 16'h1);
    spot("period_done", {15'h0, period_done}, 16'h1);
    spot("period_len", period_len, 16'hFFFF);
    spot("period_out", out, 16'hACE1);
    cycle(); @(negedge clk); spot("done_pulse", {15'h0, period_done}, 16'h0);

    // randomized traffic
    repeat (3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = $urandom_range(0, 1);
      load = ($urandom_range(0, 19) == 0);
      seed = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      init = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      cycle();
    end
    reset = 1'b0; load = 1'b0;

    @(negedge clk); @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
